// File: rtl/mul_pipe.sv
// mul_pipe: elastic, pipelined execute wrapper around a combinational
// M-extension multiplier (MUL / MULH / MULHSU / MULHU).
//   S0 captures operands, S1 registers the 64-bit product slice,
//   S2..S(STAGES-1) carry {data, rd} unchanged; the last stage drives rsp_*.
// Optional feature: define MUL_PIPE_STALL_CNT_EN to build the saturating
// backpressure counter on stall_cnt (tied to zero otherwise).
module mul_pipe #(
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [2:0]       req_mulop,
  input  logic [TAG_W-1:0] req_rd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_rd,
  output logic             busy,
  output logic [31:0]      stall_cnt
);

  // Opcode encoding shared with the issue stage; anything else acts as MULH.
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam int         LAST      = STAGES - 1;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] can_load, leave, load;
  logic              accept;

  logic [31:0]       a_q, b_q;
  logic [2:0]        op_q;
  logic [TAG_W-1:0]  rd_q   [STAGES];
  logic [31:0]       data_q [1:LAST];

  logic              sign_a, sign_b;
  logic [63:0]       ext_a, ext_b, prod;
  logic [31:0]       core_f;

  // Elastic handshake: ready ripples from the consumer back to S0, then valids advance
  always_comb begin
    can_load       = '0;
    leave          = '0;
    load           = '0;
    valid_d        = valid_q;
    accept         = 1'b0;
    leave[LAST]    = valid_q[LAST] & rsp_ready;
    can_load[LAST] = ~valid_q[LAST] | leave[LAST];
    for (int i = LAST - 1; i >= 0; i--) begin
      leave[i]    = valid_q[i] & can_load[i+1];
      can_load[i] = ~valid_q[i] | leave[i];
    end
    // Flush wins over a same-cycle request
    accept     = req_valid & can_load[0] & ~flush;
    load[0]    = accept;
    valid_d[0] = accept | (valid_q[0] & ~leave[0]);
    for (int i = 1; i < STAGES; i++) begin
      load[i]    = can_load[i] & valid_q[i-1];
      valid_d[i] = load[i] | (valid_q[i] & ~leave[i]);
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  // Multiplier core: extend each operand per opcode signedness, keep low or high half
  always_comb begin
    sign_a = (op_q != OP_MULHU);
    sign_b = (op_q != OP_MULHU) && (op_q != OP_MULHSU);
    ext_a  = {{32{sign_a & a_q[31]}}, a_q};
    ext_b  = {{32{sign_b & b_q[31]}}, b_q};
    prod   = ext_a * ext_b;
    core_f = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
  end

  // Stage occupancy flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Stage payloads; a stage only changes when it loads, so a stalled output holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        rd_q[i] <= '0;
      end
      for (int i = 1; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        a_q     <= req_a;
        b_q     <= req_b;
        op_q    <= req_mulop;
        rd_q[0] <= req_rd;
      end
      if (load[1]) begin
        data_q[1] <= core_f;
        rd_q[1]   <= rd_q[0];
      end
      for (int i = 2; i < STAGES; i++) begin
        if (load[i]) begin
          data_q[i] <= data_q[i-1];
          rd_q[i]   <= rd_q[i-1];
        end
      end
    end
  end

  assign req_ready = can_load[0];
  assign rsp_valid = valid_q[LAST];
  assign rsp_data  = data_q[LAST];
  assign rsp_rd    = rd_q[LAST];
  assign busy      = |valid_q;

`ifdef MUL_PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count cycles where a result waits on the consumer; saturates, ignores flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (valid_q[LAST] && !rsp_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: table-driven directed checks plus randomized traffic scored
// against a queue-based reference of the multiplier pipe.
module tb_mul_pipe;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [2:0]       req_mulop = '0;
  logic [TAG_W-1:0] req_rd = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_rd;
  logic             busy;
  logic [31:0]      stall_cnt;

  always #5 clk = ~clk;

  mul_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mulop(req_mulop), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [2:0]       op;
    logic [TAG_W-1:0] rd;
    logic [31:0]      exp;
  } vec_t;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] rd;
    int               acc;
  } exp_t;

  vec_t             tbl [9];
  exp_t             expq [$];
  int               ret_cyc [$];
  logic [31:0]      ret_data [$];
  logic [TAG_W-1:0] ret_rd [$];

  int total = 0, bad = 0, cyc = 0;
  int stall_model = 0, n_acc = 0, n_ret = 0;
  logic             hold_prev = 1'b0;
  logic [31:0]      hold_data = '0;
  logic [TAG_W-1:0] hold_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result: exact 64-bit product of the operands interpreted per opcode
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    longint          sa, sbv;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa  = $signed(a);
    sbv = $signed(b);
    ua  = a;
    ub  = b;
    case (op)
      OP_MUL:    return a * b;
      OP_MULHU:  p = ua * ub;
      OP_MULHSU: p = sa * ub;
      default:   p = sa * sbv;
    endcase
    return p[63:32];
  endfunction

  // One clock: sample late in the cycle, score handshakes, check state after the edge
  task automatic tick();
    exp_t e;
    logic acc, ret;
    @(negedge clk);
    #3;
    acc = req_valid & req_ready & ~flush;
    ret = rsp_valid & rsp_ready;
    chk("req_ready_capacity", {31'd0, req_ready},
        {31'd0, (expq.size() < STAGES) || rsp_ready});
    if (hold_prev) begin
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", rsp_data, hold_data);
      chk("hold_rd", {27'd0, rsp_rd}, {27'd0, hold_rd});
    end
    if (expq.size() == 0) chk("rsp_valid_when_empty", {31'd0, rsp_valid}, 32'd0);
    if (ret && expq.size() > 0) begin
      e = expq.pop_front();
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_rd", {27'd0, rsp_rd}, {27'd0, e.rd});
      n_ret++;
      ret_cyc.push_back(cyc - e.acc);
      ret_data.push_back(rsp_data);
      ret_rd.push_back(rsp_rd);
      $display("xfer cycle=%0d rd=%0d data=%h latency=%0d", cyc, rsp_rd, rsp_data, cyc - e.acc);
    end
`ifdef MUL_PIPE_STALL_CNT_EN
    if (rsp_valid && !rsp_ready) stall_model++;
`endif
    hold_prev = rsp_valid & ~rsp_ready & ~flush;
    hold_data = rsp_data;
    hold_rd   = rsp_rd;
    if (flush) expq.delete();
    if (acc) begin
      e.data = ref_mul(req_a, req_b, req_mulop);
      e.rd   = req_rd;
      e.acc  = cyc;
      expq.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("busy", {31'd0, busy}, {31'd0, expq.size() != 0});
    chk("stall_cnt", stall_cnt, stall_model);
  endtask

  task automatic drive(input vec_t v);
    req_a     = v.a;
    req_b     = v.b;
    req_mulop = v.op;
    req_rd    = v.rd;
  endtask

  task automatic clear_ret();
    ret_cyc.delete();
    ret_data.delete();
    ret_rd.delete();
  endtask

  // Retire until the model is empty, bounded
  task automatic drain(input string name);
    int k = 0;
    req_valid = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    while (expq.size() > 0 && k < 30) begin
      tick();
      k++;
    end
    chk(name, expq.size(), 32'd0);
  endtask

  // Single op with an idle pipe: fixed latency and table result
  task automatic single(input int idx);
    int a0, k;
    clear_ret();
    a0 = n_acc;
    drive(tbl[idx]);
    flush = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("single_accept", n_acc - a0, 32'd1);
    k = 0;
    while (ret_cyc.size() == 0 && k < 10) begin
      tick();
      k++;
    end
    chk("single_count", ret_cyc.size(), 32'd1);
    if (ret_cyc.size() == 1) begin
      chk("single_latency", ret_cyc[0], STAGES);
      chk("single_data", ret_data[0], tbl[idx].exp);
      chk("single_rd", {27'd0, ret_rd[0]}, {27'd0, tbl[idx].rd});
    end
  endtask

  initial begin
    int a0, r0, st0;
    vec_t v;
    tbl[0] = '{32'h0000_0007, 32'hFFFF_FFFD, OP_MUL,    5'd5, 32'hFFFF_FFEB};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULHU,  5'd1, 32'hFFFF_FFFE};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0002, OP_MULHSU, 5'd2, 32'hFFFF_FFFF};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, OP_MULH,   5'd3, 32'h4000_0000};
    tbl[4] = '{32'h0001_0000, 32'h0001_0000, OP_MUL,    5'd4, 32'h0000_0000};
    tbl[5] = '{32'h0001_0000, 32'h0001_0000, OP_MULHU,  5'd6, 32'h0000_0001};
    tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7,      5'd7, 32'h0000_0000};
    tbl[7] = '{32'hFFFF_FFFF, 32'h0000_0002, OP_MULHU,  5'd8, 32'h0000_0001};
    tbl[8] = '{32'hFFFF_FFFF, 32'h0000_0002, OP_MULH,   5'd9, 32'hFFFF_FFFF};

    // Reset state
    #2;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_rd", {27'd0, rsp_rd}, 32'd0);
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Table: every vector alone through an idle pipe
    for (int i = 0; i < 9; i++) single(i);

    // Back-to-back, one per cycle, results in consecutive cycles
    clear_ret();
    rsp_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(tbl[i]);
      req_valid = 1'b1;
      tick();
    end
    drain("b2b_drain");
    chk("b2b_count", ret_cyc.size(), 32'd3);
    if (ret_cyc.size() == 3) begin
      for (int j = 0; j < 3; j++) begin
        chk("b2b_latency", ret_cyc[j], STAGES);
        chk("b2b_data", ret_data[j], tbl[1+j].exp);
        chk("b2b_rd", {27'd0, ret_rd[j]}, {27'd0, tbl[1+j].rd});
      end
    end

    // Backpressure: continuous requests, consumer stalled; exactly STAGES accepted
    clear_ret();
    a0  = n_acc;
    r0  = n_ret;
    st0 = stall_cnt;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < STAGES + 5; i++) begin
      drive(tbl[i % 9]);
      tick();
    end
    chk("bp_accepted", n_acc - a0, STAGES);
    chk("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
`ifdef MUL_PIPE_STALL_CNT_EN
    chk("bp_stall_5", stall_cnt - st0, 32'd5);
`else
    chk("bp_stall_0", stall_cnt - st0, 32'd0);
`endif
    drain("bp_drain");
    chk("bp_retired", n_ret - r0, STAGES);

    // Flush with two ops stalled in flight and a request presented
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    drive(tbl[1]); tick();
    drive(tbl[2]); tick();
    st0 = stall_cnt;
    a0  = n_acc;
    drive(tbl[3]);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("flush_no_accept", n_acc - a0, 32'd0);
`ifdef MUL_PIPE_STALL_CNT_EN
    chk("flush_stall_kept", stall_cnt, st0 + 32'd1);
`else
    chk("flush_stall_zero", stall_cnt, 32'd0);
`endif
    single(0);

    // Flush in the same cycle as a handshake: that result is delivered, the other is not
    r0 = n_ret;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    drive(tbl[4]); tick();
    drive(tbl[5]); tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    chk("flush_retire_count", n_ret - r0, 32'd1);

    // Asynchronous reset mid-operation
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    drive(tbl[6]); tick();
    drive(tbl[7]); tick();
    drive(tbl[8]);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("areset_stall_cnt", stall_cnt, 32'd0);
    expq.delete();
    stall_model = 0;
    hold_prev = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    r0 = n_ret;
    rsp_ready = 1'b1;
    repeat (4) tick();
    chk("areset_no_reappear", n_ret - r0, 32'd0);

    // Randomized traffic against the reference queue
    for (int i = 0; i < 400; i++) begin
      v.a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      v.b  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      v.op = 3'($urandom_range(0, 7));
      v.rd = TAG_W'($urandom_range(0, 31));
      drive(v);
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    drain("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
